logic_axi4_stream_arbiter_round_robin: RTL

//  Packet-granular round-robin arbiter: shares one AXI4-Stream sink, typically the rx side of a

---
 rtl/logic_axi4_stream_arbiter_round_robin.sv | 136 +++++++++++++
 1 files changed

// File: rtl/logic_axi4_stream_arbiter_round_robin.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink between INPUTS sources.
// The grant is held from the first beat to tlast; the output stage is a single register slice.
//
//   state | meaning
//   IDLE  | no packet owns the sink; pick the next requester cyclically after last_grant
//   BUSY  | grant_q owns the sink until its tlast beat is accepted
module logic_axi4_stream_arbiter_round_robin #(
  parameter int INPUTS     = 2,
  parameter int DATA_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(INPUTS)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [INPUTS-1:0]            rx_tvalid,
  input  logic [INPUTS-1:0]            rx_tlast,
  input  logic [INPUTS*DATA_WIDTH-1:0] rx_tdata,
  output logic [INPUTS-1:0]            rx_tready,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  output logic [ID_WIDTH-1:0]          tx_tid,
  output logic [DATA_WIDTH-1:0]        tx_tdata,
  input  logic                         tx_tready
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                  tx_tvalid_q, tx_tvalid_d;
  logic                  tx_tlast_q, tx_tlast_d;
  logic [ID_WIDTH-1:0]   tx_tid_q, tx_tid_d;
  logic [DATA_WIDTH-1:0] tx_tdata_q, tx_tdata_d;

  logic                  space;
  logic                  accept;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;

  // Walk the offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = INPUTS; k >= 1; k--) begin
      if (rx_tvalid[(int'(last_grant_q) + k) % INPUTS]) begin
        pick_found = 1'b1;
        pick_idx   = ID_WIDTH'((int'(last_grant_q) + k) % INPUTS);
      end
    end
  end

  // tx_tready reaches rx_tready combinationally so a packet streams at one beat per cycle.
  assign space = !tx_tvalid_q || tx_tready;

  always_comb begin
    rx_tready = '0;
    if (state_q == S_BUSY && space) begin
      rx_tready[grant_q] = 1'b1;
    end
  end

  assign accept = (state_q == S_BUSY) && space && rx_tvalid[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_tvalid_d  = tx_tvalid_q;
    tx_tlast_d   = tx_tlast_q;
    tx_tid_d     = tx_tid_q;
    tx_tdata_d   = tx_tdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept && rx_tlast[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      tx_tvalid_d = 1'b1;
      tx_tlast_d  = rx_tlast[grant_q];
      tx_tid_d    = grant_q;
      tx_tdata_d  = rx_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    end else if (tx_tready) begin
      tx_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(INPUTS - 1);
      tx_tvalid_q  <= 1'b0;
      tx_tlast_q   <= 1'b0;
      tx_tid_q     <= '0;
      tx_tdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_tlast_q   <= tx_tlast_d;
      tx_tid_q     <= tx_tid_d;
      tx_tdata_q   <= tx_tdata_d;
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tlast  = tx_tlast_q;
  assign tx_tid    = tx_tid_q;
  assign tx_tdata  = tx_tdata_q;

`ifndef LOGIC_STD_OVL_DISABLED
  a_ready_onehot: assert property (@(posedge aclk) disable iff (areset)
    $onehot0(rx_tready));
  a_tx_stable: assert property (@(posedge aclk) disable iff (areset)
    (tx_tvalid && !tx_tready) |=> ($stable(tx_tdata) && $stable(tx_tlast) && $stable(tx_tid)));
  a_grant_range: assert property (@(posedge aclk) disable iff (areset)
    int'(grant_q) < INPUTS);
`endif

endmodule
